// File: rtl/apb3_pwm_pkg.sv
`timescale 1ns/1ps
// Register map constants shared by the APB3 PWM timer top level, its core and its users.
// Offsets are byte addresses; the SEL_* values are the decoded word index PADDR[4:2].
package apb3_pwm_pkg;

   localparam logic [4:0] OFS_CTRL   = 5'h00;
   localparam logic [4:0] OFS_PRESC  = 5'h04;
   localparam logic [4:0] OFS_PERIOD = 5'h08;
   localparam logic [4:0] OFS_DUTY   = 5'h0C;
   localparam logic [4:0] OFS_COUNT  = 5'h10;
   localparam logic [4:0] OFS_STATUS = 5'h14;

   localparam logic [2:0] SEL_CTRL   = OFS_CTRL[4:2];
   localparam logic [2:0] SEL_PRESC  = OFS_PRESC[4:2];
   localparam logic [2:0] SEL_PERIOD = OFS_PERIOD[4:2];
   localparam logic [2:0] SEL_DUTY   = OFS_DUTY[4:2];
   localparam logic [2:0] SEL_COUNT  = OFS_COUNT[4:2];
   localparam logic [2:0] SEL_STATUS = OFS_STATUS[4:2];

   localparam int CTRL_EN      = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int CTRL_POL     = 3;
   localparam int CTRL_W       = 4;

   localparam int STATUS_WRAP  = 0;

endpackage

// File: rtl/apb3_pwm_timer_if.sv
`timescale 1ns/1ps
// APB3 bus bundle between the SoC master and the PWM timer peripheral.
interface apb3_pwm_timer_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERROR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERROR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERROR
   );
endinterface

// File: rtl/apb3_pwm_core.sv
`timescale 1ns/1ps
// Prescaler, wrapping up-counter with shadowed PERIOD/DUTY, and registered PWM output.
// The wrap output is a single-cycle combinational pulse on the cycle the counter returns to 0.
module apb3_pwm_core #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] presc,
   input  logic [CNT_WIDTH-1:0] period_sh,
   input  logic [CNT_WIDTH-1:0] duty_sh,
   input  logic                 pol,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 wrap,
   output logic                 pwm_out
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] period_act_q, period_act_d;
   logic [CNT_WIDTH-1:0] duty_act_q, duty_act_d;
   logic                 pwm_q, pwm_d;
   logic                 tick;

   assign tick = en && (pcnt_q == presc);
   assign wrap = tick && (count_q == period_act_q);

   always_comb begin
      pcnt_d       = pcnt_q;
      count_d      = count_q;
      period_act_d = period_act_q;
      duty_act_d   = duty_act_q;

      if (!en) begin
         // Idle: counters parked at zero, active copies track the shadows.
         pcnt_d       = '0;
         count_d      = '0;
         period_act_d = period_sh;
         duty_act_d   = duty_sh;
      end else begin
         pcnt_d = tick ? '0 : (pcnt_q + CNT_ONE);
         if (tick) begin
            count_d = wrap ? '0 : (count_q + CNT_ONE);
         end
         if (wrap) begin
            period_act_d = period_sh;
            duty_act_d   = duty_sh;
         end
      end

      // DUTY=0 never matches, DUTY>PERIOD always matches: both fall out of the compare.
      pwm_d = (en && (count_q < duty_act_q)) ^ pol;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pcnt_q       <= '0;
         count_q      <= '0;
         period_act_q <= '0;
         duty_act_q   <= '0;
         pwm_q        <= 1'b0;
      end else begin
         pcnt_q       <= pcnt_d;
         count_q      <= count_d;
         period_act_q <= period_act_d;
         duty_act_q   <= duty_act_d;
         pwm_q        <= pwm_d;
      end
   end

   assign count   = count_q;
   assign pwm_out = pwm_q;

endmodule

// File: rtl/apb3_pwm_timer.sv
`timescale 1ns/1ps
// APB3 PWM timer: bus decode, register file, STATUS.WRAP with write-one-to-clear, and
// the level interrupt. Counting and PWM generation live in apb3_pwm_core.
module apb3_pwm_timer
   import apb3_pwm_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic            clk,
   input  logic            resetn,
   apb3_pwm_timer_if.slave apb,
   output logic            pwm_out,
   output logic            apb3Interrupt
);

   logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0]  presc_q, presc_d;
   logic [CNT_WIDTH-1:0]  period_q, period_d;
   logic [CNT_WIDTH-1:0]  duty_q, duty_d;
   logic                  wrap_flag_q, wrap_flag_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

   logic [2:0]            word_sel;
   logic                  unmapped;
   logic                  setup_ph;
   logic                  access_ph;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic [CNT_WIDTH-1:0]  count;
   logic                  wrap_pulse;
   logic                  unused_bits;

   assign word_sel  = apb.PADDR[4:2];
   assign unmapped  = (apb.PADDR[ADDR_WIDTH-1:5] != '0) || (word_sel > SEL_STATUS);
   assign setup_ph  = apb.PSEL && !apb.PENABLE;
   assign access_ph = apb.PSEL && apb.PENABLE;
   assign wr_en     = access_ph && apb.PWRITE && !unmapped;

   // Byte lanes and bits above the register widths are don't-care on writes.
   assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

   always_comb begin
      rd_mux = '0;
      if (!unmapped) begin
         case (word_sel)
            SEL_CTRL:   rd_mux[CTRL_W-1:0]    = ctrl_q;
            SEL_PRESC:  rd_mux[CNT_WIDTH-1:0] = presc_q;
            SEL_PERIOD: rd_mux[CNT_WIDTH-1:0] = period_q;
            SEL_DUTY:   rd_mux[CNT_WIDTH-1:0] = duty_q;
            SEL_COUNT:  rd_mux[CNT_WIDTH-1:0] = count;
            SEL_STATUS: rd_mux[STATUS_WRAP]   = wrap_flag_q;
            default:    rd_mux = '0;
         endcase
      end
   end

   always_comb begin
      ctrl_d      = ctrl_q;
      presc_d     = presc_q;
      period_d    = period_q;
      duty_d      = duty_q;
      wrap_flag_d = wrap_flag_q;
      prdata_d    = setup_ph ? rd_mux : prdata_q;

      // A one-shot run stops itself; an explicit CTRL write below overrides this.
      if (wrap_pulse && ctrl_q[CTRL_ONESHOT]) begin
         ctrl_d[CTRL_EN] = 1'b0;
      end

      if (wr_en) begin
         case (word_sel)
            SEL_CTRL:   ctrl_d   = apb.PWDATA[CTRL_W-1:0];
            SEL_PRESC:  presc_d  = apb.PWDATA[CNT_WIDTH-1:0];
            SEL_PERIOD: period_d = apb.PWDATA[CNT_WIDTH-1:0];
            SEL_DUTY:   duty_d   = apb.PWDATA[CNT_WIDTH-1:0];
            SEL_STATUS: begin
               if (apb.PWDATA[STATUS_WRAP]) begin
                  wrap_flag_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // A wrap in the same cycle as the clear keeps the flag set.
      if (wrap_pulse) begin
         wrap_flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ctrl_q      <= '0;
         presc_q     <= '0;
         period_q    <= '0;
         duty_q      <= '0;
         wrap_flag_q <= 1'b0;
         prdata_q    <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         presc_q     <= presc_d;
         period_q    <= period_d;
         duty_q      <= duty_d;
         wrap_flag_q <= wrap_flag_d;
         prdata_q    <= prdata_d;
      end
   end

   apb3_pwm_core #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_core (
      .clk       (clk),
      .resetn    (resetn),
      .en        (ctrl_q[CTRL_EN]),
      .presc     (presc_q),
      .period_sh (period_q),
      .duty_sh   (duty_q),
      .pol       (ctrl_q[CTRL_POL]),
      .count     (count),
      .wrap      (wrap_pulse),
      .pwm_out   (pwm_out)
   );

   assign apb.PRDATA    = prdata_q;
   assign apb.PREADY    = 1'b1;
   assign apb.PSLVERROR = resetn && access_ph && unmapped;

   assign apb3Interrupt = wrap_flag_q && ctrl_q[CTRL_IRQ_EN];

endmodule
